// File: rtl/sha3_pkg.sv
// sha3_pkg: shared word width, padding bytes and sequencer state encoding for the SHA3 absorb path
package sha3_pkg;
    localparam int WORD_W = 64;
    localparam logic [7:0] PAD_DELIM = 8'h06;
    localparam logic [7:0] PAD_FINAL = 8'h80;
    typedef enum logic [1:0] {ACCEPT, PAD, FULL} state_t;
endpackage

// File: rtl/sha3_pad_word.sv
// sha3_pad_word: keeps the first byte_num bytes of a word, inserts the delimiter, and sets the final bit
module sha3_pad_word
    import sha3_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [3:0]        byte_num,
    input  logic              last_word,
    output logic [WORD_W-1:0] out
);
    // byte_num of 8 or more keeps every byte and inserts no delimiter
    for (genvar i = 0; i < 8; i++) begin : g_byte
        assign out[WORD_W-1-8*i -: 8] =
            ((4'(i) < byte_num) ? in[WORD_W-1-8*i -: 8] : (4'(i) == byte_num) ? PAD_DELIM : 8'h00) |
            ((i == 7 && last_word) ? PAD_FINAL : 8'h00);
    end
endmodule

// File: rtl/sha3_padder_seq.sv
// sha3_padder_seq: gathers host words into a rate block, pads the message end, and hands blocks to f_permutation
module sha3_padder_seq
    import sha3_pkg::*;
#(
    parameter int RATE = 576
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [63:0]     in,
    input  logic            in_ready,
    input  logic            is_last,
    input  logic [3:0]      byte_num,
    output logic            buffer_full,
    output logic [RATE-1:0] out,
    output logic            out_ready,
    input  logic            f_ack
);
    localparam int WORDS = RATE / WORD_W;
    localparam int CW = $clog2(WORDS + 1);
    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic msg_end, delim_done, take, done, short_last, pw_final;
    logic [3:0] pw_bn;
    logic [WORD_W-1:0] pw_in, pw_out;
    sha3_pad_word u_pad (
        .in(pw_in),
        .byte_num(pw_bn),
        .last_word(pw_final),
        .out(pw_out)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCEPT;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        unique case (state)
            ACCEPT:  if (take) state_next = done ? FULL : is_last ? PAD : ACCEPT;
            PAD:     if (done) state_next = FULL;
            FULL:    if (f_ack) state_next = (msg_end & ~delim_done) ? PAD : ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end
    // every stored word goes through the padder; full data words use byte_num 8 with no final bit
    always_comb begin
        take = (state == ACCEPT) ? in_ready & ~buffer_full : (state == PAD);
        done = take & (cnt == CW'(WORDS - 1));
        short_last = is_last & (byte_num < 4'd8);
        pw_in = (state == ACCEPT) ? in : '0;
        pw_bn = (state == ACCEPT) ? (short_last ? byte_num : 4'd8) : (delim_done ? 4'd8 : 4'd0);
        pw_final = (cnt == CW'(WORDS - 1)) & ((state == PAD) | short_last);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            out <= '0;
            out_ready <= 1'b0;
            buffer_full <= 1'b0;
            msg_end <= 1'b0;
            delim_done <= 1'b0;
        end else begin
            if (state == FULL && f_ack) cnt <= '0;
            else if (take) cnt <= cnt + 1'b1;
            if (take) out <= {out[RATE-WORD_W-1:0], pw_out};
            out_ready <= state_next == FULL;
            buffer_full <= state_next != ACCEPT;
            if (state == ACCEPT && take && is_last) begin
                msg_end <= 1'b1;
                delim_done <= short_last;
            end else if (state == PAD) begin
                delim_done <= 1'b1;
            end else if (state == FULL && f_ack && delim_done) begin
                msg_end <= 1'b0;
                delim_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sha3_padder_seq.sv
// tb_sha3_padder_seq: directed and randomized messages checked against a byte-level SHA3 padding model
module tb_sha3_padder_seq;
    localparam int RATE = 576;
    localparam int WORDS = 9;
    localparam int RB = RATE / 8;
    logic clk = 0, reset, in_ready, is_last, f_ack, buffer_full, out_ready;
    logic [63:0] in;
    logic [3:0] byte_num;
    logic [RATE-1:0] out;
    int vectors = 0, miscompares = 0;
    logic [RATE-1:0] exp_q[$];
    logic [63:0] msg[$];

    sha3_padder_seq #(.RATE(RATE)) dut (
        .clk(clk), .reset(reset), .in(in), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .buffer_full(buffer_full), .out(out), .out_ready(out_ready), .f_ack(f_ack)
    );

    always #5 clk = ~clk;

    // message bytes, then 0x06, zero fill to a rate multiple, final byte ORed with 0x80
    function automatic void build(input int bn);
        byte unsigned b[$];
        int nb;
        logic [RATE-1:0] blk;
        for (int w = 0; w < msg.size(); w++) begin
            nb = (w == msg.size() - 1) ? ((bn > 8) ? 8 : bn) : 8;
            for (int k = 0; k < nb; k++) b.push_back(msg[w][63-8*k -: 8]);
        end
        b.push_back(8'h06);
        while (b.size() % RB != 0) b.push_back(8'h00);
        b[b.size()-1] = b[b.size()-1] | 8'h80;
        for (int s = 0; s < b.size(); s += RB) begin
            blk = '0;
            for (int j = 0; j < RB; j++) blk = {blk[RATE-9:0], b[s+j]};
            exp_q.push_back(blk);
        end
    endfunction

    task automatic service(input int ack_pct);
        f_ack = 0;
        if (out_ready && $urandom_range(99) < ack_pct) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_block got %h", out);
            end else begin
                if (out !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL block got %h want %h", out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            f_ack = 1;
        end
        @(posedge clk);
        #1;
        f_ack = 0;
    endtask

    task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] bn, input int ack_pct);
        int g = 0;
        in = w;
        is_last = last;
        byte_num = bn;
        in_ready = 1;
        while (buffer_full && g < 300) begin
            service(ack_pct);
            g++;
        end
        if (buffer_full) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout buffer_full=%b want 0", buffer_full);
        end else service(ack_pct);
        in_ready = 0;
        is_last = 0;
        in = 64'($urandom());
    endtask

    task automatic drain(input int ack_pct);
        int g = 0;
        while (exp_q.size() > 0 && g < 500) begin
            service(ack_pct);
            g++;
        end
        vectors++;
        if (exp_q.size() != 0 || buffer_full !== 1'b0) begin
            miscompares++;
            $display("FAIL drain left=%0d buffer_full=%b want 0/0", exp_q.size(), buffer_full);
        end
        exp_q.delete();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!out_ready && n < 100) begin
            vectors++;
            if (buffer_full !== 1'b1) begin
                miscompares++;
                $display("FAIL pad_blocked buffer_full=%b want 1", buffer_full);
            end
            service(0);
            n++;
        end
    endtask

    task automatic send_msg(input int bn, input int ack_pct, input int gap_max);
        build(bn);
        for (int i = 0; i < msg.size(); i++) begin
            send_word(msg[i], i == msg.size() - 1, (i == msg.size() - 1) ? 4'(bn) : 4'($urandom()), ack_pct);
            repeat ($urandom_range(gap_max)) service(ack_pct);
        end
        drain(ack_pct);
        msg.delete();
    endtask

    task automatic test_reset();
        reset = 1;
        in_ready = 0;
        f_ack = 0;
        in = '0;
        is_last = 0;
        byte_num = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out !== '0 || out_ready !== 1'b0 || buffer_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset out_nonzero=%b out_ready=%b buffer_full=%b want 0/0/0", |out, out_ready, buffer_full);
        end
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word(input logic [63:0] w, input logic [3:0] bn, input logic [RATE-1:0] want);
        int n;
        msg.push_back(w);
        build(bn);
        send_word(w, 1, bn, 0);
        wait_ready(n);
        vectors++;
        if (n != 8 || out !== want) begin
            miscompares++;
            $display("FAIL single_word pad_cycles=%0d want 8 got %h want %h", n, out, want);
        end
        drain(100);
        msg.delete();
    endtask

    task automatic test_last7();
        int n;
        for (int i = 0; i < 8; i++) msg.push_back({$urandom(), $urandom()});
        msg.push_back(64'h1234567890ABCDEF);
        build(7);
        for (int i = 0; i < 9; i++) send_word(msg[i], i == 8, (i == 8) ? 4'd7 : 4'($urandom()), 0);
        wait_ready(n);
        vectors++;
        if (n != 0 || out[63:0] !== 64'h1234567890ABCD86) begin
            miscompares++;
            $display("FAIL last7 pad_cycles=%0d want 0 word8=%h want 1234567890abcd86", n, out[63:0]);
        end
        drain(100);
        msg.delete();
    endtask

    task automatic test_bn8();
        int n;
        logic [RATE-1:0] want2;
        want2 = {64'h0600000000000000, {7{64'h0}}, 64'h80};
        for (int i = 0; i < 9; i++) msg.push_back({$urandom(), $urandom()});
        build(8);
        for (int i = 0; i < 9; i++) send_word(msg[i], i == 8, 4'd8, 0);
        wait_ready(n);
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL bn8_first pad_cycles=%0d want 0", n);
        end
        service(100);
        wait_ready(n);
        vectors++;
        if (n != 9 || out !== want2) begin
            miscompares++;
            $display("FAIL bn8_second pad_cycles=%0d want 9 got %h want %h", n, out, want2);
        end
        drain(100);
        msg.delete();
    endtask

    task automatic test_backpressure();
        int n;
        logic [63:0] x;
        logic [3:0] bn;
        x = {$urandom(), $urandom()};
        bn = 4'($urandom_range(0, 8));
        for (int i = 0; i < 9; i++) msg.push_back({$urandom(), $urandom()});
        msg.push_back(x);
        msg.push_back({$urandom(), $urandom()});
        build(bn);
        for (int i = 0; i < 9; i++) send_word(msg[i], 0, 4'($urandom()), 0);
        wait_ready(n);
        in = x;
        is_last = 0;
        in_ready = 1;
        repeat (4) begin
            vectors++;
            if (buffer_full !== 1'b1 || out_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL hold buffer_full=%b out_ready=%b want 1/1", buffer_full, out_ready);
            end
            service(0);
        end
        service(100);
        vectors++;
        if (buffer_full !== 1'b0 || out_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL after_ack buffer_full=%b out_ready=%b want 0/0", buffer_full, out_ready);
        end
        @(posedge clk);
        #1;
        in_ready = 0;
        vectors++;
        if (out[63:0] !== x || out[127:64] !== msg[8] || buffer_full !== 1'b0) begin
            miscompares++;
            $display("FAIL first_after_ack got %h/%h want %h/%h", out[127:64], out[63:0], msg[8], x);
        end
        send_word(msg[10], 1, bn, 0);
        drain(100);
        msg.delete();
    endtask

    task automatic test_reset_mid_pad();
        for (int i = 0; i < 4; i++) msg.push_back({$urandom(), $urandom()});
        for (int i = 0; i < 4; i++) send_word(msg[i], i == 3, 4'd2, 0);
        reset = 1;
        #1;
        vectors++;
        if (out !== '0 || out_ready !== 1'b0 || buffer_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_pad out_nonzero=%b out_ready=%b buffer_full=%b want 0/0/0", |out, out_ready, buffer_full);
        end
        msg.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 5; i++) msg.push_back({$urandom(), $urandom()});
        send_msg($urandom_range(0, 8), 100, 1);
    endtask

    task automatic test_random();
        repeat (25) begin
            int nw;
            nw = $urandom_range(1, 20);
            for (int i = 0; i < nw; i++) msg.push_back({$urandom(), $urandom()});
            send_msg($urandom_range(0, 15), $urandom_range(30, 100), 3);
        end
    endtask

    initial begin
        test_reset();
        test_single_word(64'h1234567890ABCDEF, 4'd3, {64'h1234560600000000, {7{64'h0}}, 64'h80});
        test_single_word({$urandom(), $urandom()}, 4'd0, {64'h0600000000000000, {7{64'h0}}, 64'h80});
        test_last7();
        test_bn8();
        test_backpressure();
        test_reset_mid_pad();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
